// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
package riscv_pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    PIPE_S_RUN     = 2'd0,
    PIPE_S_MD_WAIT = 2'd1,
    PIPE_S_DM_WAIT = 2'd2,
    PIPE_S_FLUSH   = 2'd3
  } pipe_state_e;

  // One source operand collides with the EX destination register.
  function automatic logic src_hazard(input logic                 used,
                                      input logic [REG_IDX_W-1:0] rs,
                                      input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_if.sv
// Hazard inputs and stage-register controls between the datapath and the sequencer.
interface riscv_pipe_ctrl_if #(parameter int CNT_W = 16);
  import riscv_pipe_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] i_id_rs1;
  logic [REG_IDX_W-1:0] i_id_rs2;
  logic                 i_id_rs1_used;
  logic                 i_id_rs2_used;
  logic [REG_IDX_W-1:0] i_ex_rd;
  logic                 i_ex_rd_we;
  logic                 i_ex_is_load;
  logic                 i_ex_md_start;
  logic                 i_md_done;
  logic                 i_dmem_req;
  logic                 i_dmem_ready;
  logic                 i_ex_redirect;
  logic                 i_trap;
  logic                 o_pc_hold;
  logic                 o_ifid_en;
  logic                 o_idex_en;
  logic                 o_exmem_en;
  logic                 o_ifid_clr;
  logic                 o_idex_clr;
  logic                 o_exmem_clr;
  logic [1:0]           o_state;
  logic                 o_md_timeout;
  logic [CNT_W-1:0]     o_stall_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_rd_we,
           i_ex_is_load, i_ex_md_start, i_md_done, i_dmem_req, i_dmem_ready,
           i_ex_redirect, i_trap,
    input  o_pc_hold, o_ifid_en, o_idex_en, o_exmem_en, o_ifid_clr, o_idex_clr,
           o_exmem_clr, o_state, o_md_timeout, o_stall_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd, i_ex_rd_we,
           i_ex_is_load, i_ex_md_start, i_md_done, i_dmem_req, i_dmem_ready,
           i_ex_redirect, i_trap,
    output o_pc_hold, o_ifid_en, o_idex_en, o_exmem_en, o_ifid_clr, o_idex_clr,
           o_exmem_clr, o_state, o_md_timeout, o_stall_cnt
  );

endinterface

// File: rtl/riscv_pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX feeding a source of the ID instruction.
module riscv_hazard_detect
  import riscv_pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_rd_we,
  input  logic                 i_ex_is_load,
  output logic                 o_load_use
);

  logic w_rd_live;

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign w_rd_live  = i_ex_is_load && i_ex_rd_we && (i_ex_rd != {REG_IDX_W{1'b0}});
  assign o_load_use = w_rd_live &&
                      (src_hazard(i_id_rs1_used, i_id_rs1, i_ex_rd) ||
                       src_hazard(i_id_rs2_used, i_id_rs2, i_ex_rd));

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX and EX/MEM pipeline registers.
module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MD_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  riscv_pipe_ctrl_if.slave bus
);

  localparam int                    MD_CNT_W  = $clog2(MD_TIMEOUT);
  localparam logic [MD_CNT_W-1:0]   MD_LAST   = MD_CNT_W'(MD_TIMEOUT - 1);
  localparam logic [MD_CNT_W-1:0]   MD_ONE    = MD_CNT_W'(1'b1);
  localparam logic [2:0]            FL_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);

  pipe_state_e         r_state;
  pipe_state_e         w_next_state;
  logic [2:0]          r_flush_cnt;
  logic [2:0]          w_flush_cnt_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_load_use;
  logic                w_dm_stall;
  logic                w_pc_hold;
  logic                w_ifid_en;
  logic                w_idex_en;
  logic                w_exmem_en;
  logic                w_ifid_clr;
  logic                w_idex_clr;
  logic                w_exmem_clr;
  logic                w_md_timeout;

  riscv_hazard_detect u_hazard (
    .i_id_rs1      (bus.i_id_rs1),
    .i_id_rs2      (bus.i_id_rs2),
    .i_id_rs1_used (bus.i_id_rs1_used),
    .i_id_rs2_used (bus.i_id_rs2_used),
    .i_ex_rd       (bus.i_ex_rd),
    .i_ex_rd_we    (bus.i_ex_rd_we),
    .i_ex_is_load  (bus.i_ex_is_load),
    .o_load_use    (w_load_use)
  );

  assign w_dm_stall = bus.i_dmem_req && !bus.i_dmem_ready;

  // Priority decode: trap, data-memory wait, mul/div wait, redirect/flush, load-use.
  always_comb begin
    w_next_state    = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_md_cnt_nxt    = r_md_cnt;
    w_pc_hold       = 1'b0;
    w_ifid_en       = 1'b0;
    w_idex_en       = 1'b0;
    w_exmem_en      = 1'b0;
    w_ifid_clr      = 1'b0;
    w_idex_clr      = 1'b0;
    w_exmem_clr     = 1'b0;
    w_md_timeout    = 1'b0;
    if (!i_rstn) begin
      w_next_state    = PIPE_S_RUN;
      w_flush_cnt_nxt = 3'd0;
      w_md_cnt_nxt    = {MD_CNT_W{1'b0}};
    end else if (bus.i_trap) begin
      w_ifid_clr      = 1'b1;
      w_idex_clr      = 1'b1;
      w_exmem_clr     = 1'b1;
      w_next_state    = PIPE_S_RUN;
      w_flush_cnt_nxt = 3'd0;
      w_md_cnt_nxt    = {MD_CNT_W{1'b0}};
    end else if (w_dm_stall) begin
      w_pc_hold       = 1'b1;
      w_ifid_en       = 1'b1;
      w_idex_en       = 1'b1;
      w_exmem_en      = 1'b1;
      w_next_state    = PIPE_S_DM_WAIT;
      w_flush_cnt_nxt = 3'd0;
      w_md_cnt_nxt    = {MD_CNT_W{1'b0}};
    end else if (r_state == PIPE_S_MD_WAIT) begin
      if (bus.i_md_done) begin
        w_next_state = PIPE_S_RUN;
        w_md_cnt_nxt = {MD_CNT_W{1'b0}};
      end else begin
        w_pc_hold   = 1'b1;
        w_ifid_en   = 1'b1;
        w_idex_en   = 1'b1;
        w_exmem_clr = 1'b1;
        if (r_md_cnt == MD_LAST) begin
          w_md_timeout = 1'b1;
          w_next_state = PIPE_S_RUN;
          w_md_cnt_nxt = {MD_CNT_W{1'b0}};
        end else begin
          w_md_cnt_nxt = r_md_cnt + MD_ONE;
        end
      end
    end else begin
      // RUN, FLUSH, or the cycle a data-memory wait resolves.
      w_next_state = PIPE_S_RUN;
      if (bus.i_ex_redirect) begin
        w_ifid_clr = 1'b1;
        w_idex_clr = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_next_state    = PIPE_S_FLUSH;
          w_flush_cnt_nxt = FL_RELOAD;
        end else begin
          w_flush_cnt_nxt = 3'd0;
        end
      end else if (r_state == PIPE_S_FLUSH) begin
        w_ifid_clr = 1'b1;
        w_idex_clr = 1'b1;
        if (r_flush_cnt <= 3'd1) begin
          w_flush_cnt_nxt = 3'd0;
        end else begin
          w_next_state    = PIPE_S_FLUSH;
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end else if (w_load_use) begin
        w_pc_hold  = 1'b1;
        w_ifid_en  = 1'b1;
        w_idex_clr = 1'b1;
      end else begin
        w_flush_cnt_nxt = 3'd0;
      end
      if (bus.i_ex_md_start && (r_state != PIPE_S_FLUSH)) begin
        w_next_state = PIPE_S_MD_WAIT;
        w_md_cnt_nxt = {MD_CNT_W{1'b0}};
      end else begin
        w_md_cnt_nxt = {MD_CNT_W{1'b0}};
      end
    end
  end

  // FSM state and the flush / mul-div timeout counters.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= PIPE_S_RUN;
      r_flush_cnt <= 3'd0;
      r_md_cnt    <= {MD_CNT_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_md_cnt    <= w_md_cnt_nxt;
    end
  end

  // Saturating count of PC-hold cycles; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign bus.o_pc_hold    = w_pc_hold;
  assign bus.o_ifid_en    = w_ifid_en;
  assign bus.o_idex_en    = w_idex_en;
  assign bus.o_exmem_en   = w_exmem_en;
  assign bus.o_ifid_clr   = w_ifid_clr;
  assign bus.o_idex_clr   = w_idex_clr;
  assign bus.o_exmem_clr  = w_exmem_clr;
  assign bus.o_md_timeout = w_md_timeout;
  assign bus.o_state      = r_state;
  assign bus.o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl: load-use, flush, mul/div wait/timeout, dmem wait, trap, reset.
module tb_riscv_pipe_ctrl;

  logic r_clk;
  logic r_rstn;
  int   n_checks;
  int   n_errors;

  // Control vector order: {pc_hold, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, exmem_clr}
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LU    = 7'b110_0010;
  localparam logic [6:0] C_FLUSH = 7'b000_0110;
  localparam logic [6:0] C_MD    = 7'b111_0001;
  localparam logic [6:0] C_DM    = 7'b111_1000;
  localparam logic [6:0] C_TRAP  = 7'b000_0111;

  riscv_pipe_ctrl_if #(.CNT_W(4)) u_if ();

  riscv_pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .MD_TIMEOUT   (64),
    .CNT_W        (4)
  ) u_dut (
    .i_clk  (r_clk),
    .i_rstn (r_rstn),
    .bus    (u_if.slave)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl();
    return {u_if.o_pc_hold, u_if.o_ifid_en, u_if.o_idex_en, u_if.o_exmem_en,
            u_if.o_ifid_clr, u_if.o_idex_clr, u_if.o_exmem_clr};
  endfunction

  task automatic idle();
    u_if.i_id_rs1      = 5'd0;
    u_if.i_id_rs2      = 5'd0;
    u_if.i_id_rs1_used = 1'b0;
    u_if.i_id_rs2_used = 1'b0;
    u_if.i_ex_rd       = 5'd0;
    u_if.i_ex_rd_we    = 1'b0;
    u_if.i_ex_is_load  = 1'b0;
    u_if.i_ex_md_start = 1'b0;
    u_if.i_md_done     = 1'b0;
    u_if.i_dmem_req    = 1'b0;
    u_if.i_dmem_ready  = 1'b0;
    u_if.i_ex_redirect = 1'b0;
    u_if.i_trap        = 1'b0;
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  // Check combinational controls for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    check(tag, {25'd0, ctrl()}, {25'd0, exp});
    tick();
  endtask

  task automatic set_load(input logic [4:0] rd);
    u_if.i_ex_is_load = 1'b1;
    u_if.i_ex_rd_we   = 1'b1;
    u_if.i_ex_rd      = rd;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    r_rstn   = 1'b0;
    idle();
    #2;
    check("rst_state", {30'd0, u_if.o_state}, 32'd0);
    check("rst_ctrl", {25'd0, ctrl()}, 32'd0);
    check("rst_cnt", {28'd0, u_if.o_stall_cnt}, 32'd0);
    check("rst_tmo", {31'd0, u_if.o_md_timeout}, 32'd0);
    #10 r_rstn = 1'b1;
    tick();

    // Load-use hazards
    idle(); set_load(5'd5); u_if.i_id_rs2 = 5'd5; u_if.i_id_rs2_used = 1'b1;
    cyc("lu_rs2", C_LU);
    check("lu_cnt1", {28'd0, u_if.o_stall_cnt}, 32'd1);
    check("lu_state", {30'd0, u_if.o_state}, 32'd0);
    idle(); u_if.i_id_rs2 = 5'd5; u_if.i_id_rs2_used = 1'b1;
    cyc("lu_one_bubble", C_NONE);
    idle(); set_load(5'd0); u_if.i_id_rs1 = 5'd0; u_if.i_id_rs1_used = 1'b1;
    cyc("lu_x0", C_NONE);
    idle(); set_load(5'd7); u_if.i_id_rs1 = 5'd7; u_if.i_id_rs1_used = 1'b0;
    cyc("lu_unused", C_NONE);
    idle(); set_load(5'd7); u_if.i_id_rs1 = 5'd7; u_if.i_id_rs1_used = 1'b1;
    cyc("lu_rs1", C_LU);
    idle(); set_load(5'd7); u_if.i_ex_rd_we = 1'b0; u_if.i_id_rs1 = 5'd7; u_if.i_id_rs1_used = 1'b1;
    cyc("lu_no_we", C_NONE);
    check("lu_cnt2", {28'd0, u_if.o_stall_cnt}, 32'd2);

    // Redirect with FLUSH_CYCLES=3; load-use masked while flushing
    idle(); u_if.i_ex_redirect = 1'b1; set_load(5'd3); u_if.i_id_rs1 = 5'd3; u_if.i_id_rs1_used = 1'b1;
    cyc("fl_c0", C_FLUSH);
    check("fl_state", {30'd0, u_if.o_state}, 32'd3);
    u_if.i_ex_redirect = 1'b0;
    cyc("fl_c1", C_FLUSH);
    idle();
    cyc("fl_c2", C_FLUSH);
    cyc("fl_c3", C_NONE);
    check("fl_run", {30'd0, u_if.o_state}, 32'd0);
    u_if.i_ex_redirect = 1'b1;
    cyc("fl2_c0", C_FLUSH);
    cyc("fl2_c1_restart", C_FLUSH);
    u_if.i_ex_redirect = 1'b0;
    cyc("fl2_c2", C_FLUSH);
    cyc("fl2_c3", C_FLUSH);
    cyc("fl2_c4", C_NONE);
    check("fl_cnt", {28'd0, u_if.o_stall_cnt}, 32'd2);

    // Mul/div completing after 10 wait cycles
    idle(); u_if.i_ex_md_start = 1'b1;
    cyc("md_start", C_NONE);
    u_if.i_ex_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("md_state", {30'd0, u_if.o_state}, 32'd1);
      cyc("md_wait", C_MD);
    end
    u_if.i_md_done = 1'b1;
    cyc("md_done", C_NONE);
    u_if.i_md_done = 1'b0;
    check("md_exit", {30'd0, u_if.o_state}, 32'd0);
    check("md_cnt", {28'd0, u_if.o_stall_cnt}, 32'd12);

    // Data-memory wait aborted by a trap, then a zero-wait access
    idle(); u_if.i_dmem_req = 1'b1;
    cyc("dm_c0", C_DM);
    check("dm_state", {30'd0, u_if.o_state}, 32'd2);
    cyc("dm_c1", C_DM);
    u_if.i_trap = 1'b1;
    cyc("dm_trap", C_TRAP);
    check("trap_state", {30'd0, u_if.o_state}, 32'd0);
    idle(); u_if.i_dmem_req = 1'b1; u_if.i_dmem_ready = 1'b1;
    cyc("dm_zero_wait", C_NONE);
    check("dm_zw_state", {30'd0, u_if.o_state}, 32'd0);
    check("dm_cnt", {28'd0, u_if.o_stall_cnt}, 32'd14);

    // Mul/div timeout after 64 cycles; stall counter saturates at 15
    idle(); u_if.i_ex_md_start = 1'b1;
    tick();
    u_if.i_ex_md_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check("tmo_ctrl", {25'd0, ctrl()}, {25'd0, C_MD});
      check("tmo_pulse", {31'd0, u_if.o_md_timeout}, (i == 63) ? 32'd1 : 32'd0);
      tick();
    end
    check("tmo_state", {30'd0, u_if.o_state}, 32'd0);
    check("tmo_pulse_off", {31'd0, u_if.o_md_timeout}, 32'd0);
    check("sat_cnt", {28'd0, u_if.o_stall_cnt}, 32'd15);

    // Asynchronous reset while in MD_WAIT
    u_if.i_ex_md_start = 1'b1;
    tick();
    u_if.i_ex_md_start = 1'b0;
    tick();
    check("ar_pre_state", {30'd0, u_if.o_state}, 32'd1);
    #2 r_rstn = 1'b0;
    #1;
    check("ar_state", {30'd0, u_if.o_state}, 32'd0);
    check("ar_ctrl", {25'd0, ctrl()}, 32'd0);
    check("ar_cnt", {28'd0, u_if.o_stall_cnt}, 32'd0);
    #2 r_rstn = 1'b1;
    tick();
    cyc("ar_after", C_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
